// File: rtl/timing_tap_array.sv
// Launch/capture timing-characterisation block: one launch register drives a buffer
// delay chain, strided taps are captured, compared against the ideal value and the mismatches counted.

module timing_tap_buf (
   input  logic a,
   output logic y
);
   assign y = a;
endmodule

module timing_tap_array #(
   parameter int WIDTH      = 1,
   parameter int DEPTH      = 6,
   parameter int NUM_TAPS   = 5,
   parameter int TAP_STRIDE = 1,
   parameter int CNT_W      = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      clear,
   input  logic                      mode,
   input  logic [WIDTH-1:0]          data_in,
   input  logic [NUM_TAPS-1:0]       inj_tap,
   output logic [NUM_TAPS*WIDTH-1:0] tap_q,
   output logic [NUM_TAPS-1:0]       err_flag,
   output logic [NUM_TAPS*CNT_W-1:0] err_cnt
);

   localparam int TOT_W = NUM_TAPS * WIDTH;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   if (NUM_TAPS * TAP_STRIDE > DEPTH) begin : g_bad_cfg
      $error("timing_tap_array: NUM_TAPS*TAP_STRIDE exceeds DEPTH");
   end

   logic [15:0]              lfsr_q, lfsr_d;
   logic [WIDTH-1:0]         launch_q, launch_d;
   logic [WIDTH-1:0]         exp_q;
   logic [TOT_W-1:0]         cap_q, cap_d;
   logic [TOT_W-1:0]         chain_tap_s;
   logic                     v1_q, v1_d, v2_q, v2_d;
   logic [NUM_TAPS-1:0]      flag_q, flag_d;
   logic [NUM_TAPS*CNT_W-1:0] cnt_q, cnt_d;

   // Delay chain: one kept buffer instance per stage and lane so timing sees every stage
   for (genvar i = 0; i <= DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] out_s;
      if (i == 0) begin : g_src
         assign out_s = launch_q;
      end else begin : g_buf
         for (genvar j = 0; j < WIDTH; j++) begin : g_lane
            (* dont_touch = "true", keep_hierarchy = "yes" *)
            timing_tap_buf u_buf (
               .a (g_stage[i-1].out_s[j]),
               .y (out_s[j])
            );
         end
      end
   end

   for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
      assign chain_tap_s[k*WIDTH +: WIDTH] = g_stage[(k+1)*TAP_STRIDE].out_s;
   end

   // Launch path and PRBS source (x^16+x^14+x^13+x^11+1, shift left)
   always_comb begin
      lfsr_d   = lfsr_q;
      launch_d = launch_q;
      if (en) begin
         if (mode) begin
            launch_d = lfsr_q[WIDTH-1:0];
            lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         end else begin
            launch_d = data_in;
         end
      end else begin
         launch_d = launch_q;
      end
   end

   // Capture with per-tap fault injection on lane 0
   always_comb begin
      cap_d = chain_tap_s;
      for (int k = 0; k < NUM_TAPS; k++) begin
         cap_d[k*WIDTH] = chain_tap_s[k*WIDTH] ^ inj_tap[k];
      end
   end

   // Check pipeline and saturating error accounting; clear wins over increment
   always_comb begin
      v1_d   = en;
      v2_d   = v1_q;
      cnt_d  = cnt_q;
      flag_d = flag_q;
      if (clear) begin
         v1_d   = 1'b0;
         v2_d   = 1'b0;
         cnt_d  = '0;
         flag_d = '0;
      end else if (v2_q) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            if (cap_q[k*WIDTH +: WIDTH] != exp_q) begin
               flag_d[k] = 1'b1;
               if (cnt_q[k*CNT_W +: CNT_W] != CNT_MAX) begin
                  cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
               end else begin
                  cnt_d[k*CNT_W +: CNT_W] = CNT_MAX;
               end
            end else begin
               cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W];
            end
         end
      end else begin
         cnt_d  = cnt_q;
         flag_d = flag_q;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q   <= 16'hACE1;
         launch_q <= '0;
         exp_q    <= '0;
         cap_q    <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         flag_q   <= '0;
         cnt_q    <= '0;
      end else begin
         lfsr_q   <= lfsr_d;
         launch_q <= launch_d;
         exp_q    <= launch_q;
         cap_q    <= cap_d;
         v1_q     <= v1_d;
         v2_q     <= v2_d;
         flag_q   <= flag_d;
         cnt_q    <= cnt_d;
      end
   end

   assign tap_q    = cap_q;
   assign err_flag = flag_q;
   assign err_cnt  = cnt_q;

endmodule

// File: doc/timing_tap_array.md
Name: timing_tap_array

Overview:
- Parametrised launch/capture timing-characterisation block: one launch register drives a DEPTH-stage buffer delay chain.
- NUM_TAPS capture registers sample the chain at evenly strided taps.
- Each capture is compared against the ideal (zero-delay) value; per-tap saturating error counters and sticky flags record mismatches.
- Used in STA/gate-level-SDF regression designs to correlate reported path slack per path group with observed capture failures. Adds a WIDTH-bit data path, internal PRBS source, fault injection and error accounting.

Parameters:
- WIDTH, 1, data lanes per stage (1..16).
- DEPTH, 6, buffer stages in the delay chain (>=1).
- NUM_TAPS, 5, capture points (>=1).
- TAP_STRIDE, 1, buffers between consecutive taps; tap k follows (k+1)*TAP_STRIDE buffers; NUM_TAPS*TAP_STRIDE <= DEPTH (elaboration error otherwise).
- CNT_W, 8, width of each error counter.

Ports:
- clk, input, 1, single clock; all flops rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, launch enable.
- clear, input, 1, synchronous clear of counters, flags and check pipeline.
- mode, input, 1, 0 = launch data_in, 1 = launch internal LFSR.
- data_in, input, WIDTH, external launch data.
- inj_tap, input, NUM_TAPS, fault injection: bit k inverts lane 0 of tap k's chain output before its capture flop.
- tap_q, output, NUM_TAPS*WIDTH, capture register contents; tap k at [k*WIDTH +: WIDTH].
- err_flag, output, NUM_TAPS, sticky mismatch flag per tap.
- err_cnt, output, NUM_TAPS*CNT_W, per-tap error count; tap k at [k*CNT_W +: CNT_W].

Behaviour:
- Reset (rst_n=0, async): launch reg L=0, exp=0, all tap_q=0, err_flag=0, err_cnt=0, v1=v2=0, LFSR=16'hACE1.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts left, feedback into bit 0. Advances only on edges with en=1 && mode=1.
- Launch: at each edge with en=1, L <= (mode ? LFSR[WIDTH-1:0] current value : data_in). With en=0, L holds.
- Delay chain: purely combinational. Stage i = BUF of stage i-1; stage 0 = L. Each stage must be a separate buffer cell instance per lane; no logic merging (keep hierarchy / dont_touch).
- Capture: every edge, tap_q[k] <= chain stage (k+1)*TAP_STRIDE, with lane 0 XOR inj_tap[k]. In the same edge, exp <= L.
- Check pipeline: v1 <= en; v2 <= v1.
- Compare: at each edge with v2=1 and clear=0, for each k with tap_q[k] != exp:
  - err_cnt[k] increments, saturating at 2^CNT_W-1 (no wrap);
  - err_flag[k] <= 1.
- Latency: data launched at edge t appears on tap_q after edge t+1. A mismatch is reflected in err_cnt/err_flag after edge t+2.
- clear=1: err_cnt, err_flag, v1, v2 <= 0 at the edge. clear has priority over increment in the same cycle. L, LFSR and tap_q are unaffected.
- en dropping: in-flight checks complete (v pipeline drains over 2 edges); after that no further counting.
- Mode switch mid-run: takes effect on the next launch edge. The LFSR retains its state while mode=0.
- Reset mid-run: all state returns to reset values immediately, regardless of clk.
- Functional (zero-delay) simulation with inj_tap=0: counters never increment.

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Release, mode=1, en=1 -> first launched value 16'hACE1[WIDTH-1:0]; tap_q shows it after the next edge.
- Latency (WIDTH=4, mode=0): data_in=4'h5 at launch edge t, en=1 -> every tap_q[k]=4'h5 after edge t+1; err_cnt all 0.
- Injection: inj_tap=5'b00100 for 3 consecutive checked cycles -> err_cnt[2]=3 and err_flag[2]=1; other taps stay 0.
- Saturation: CNT_W=2, inj_tap[0]=1 for 6 checked cycles -> err_cnt[0]=3, no wrap.
- Clear priority: clear=1 in a cycle with an injected mismatch -> err_cnt=0 and err_flag=0 after the edge. inj_tap[k] stays ineffective for the next 2 edges while v refills.
- en=0 for 10 cycles with inj_tap all-ones -> no increment once the pipeline drains. The LFSR value is unchanged across the gap.
